// File: rtl/uart_baud_pkg.sv
// Shared types and rate table for the UART baud generator.
//   baud_sel_t  : 3-bit rate code (000=300 ... 111=115200)
//   baud_rate() : rate code -> baud in bits per second
//   baud_step() : per-clock phase increment, baud x oversample
package uart_baud_pkg;

  typedef logic [2:0] baud_sel_t;

  localparam int unsigned NUM_RATES      = 8;
  localparam int unsigned MAX_BAUD       = 115_200;
  localparam int unsigned MIN_OVERSAMPLE = 2;
  localparam int unsigned MAX_OVERSAMPLE = 64;

  // Rate code to baud.
  function automatic int unsigned baud_rate(input baud_sel_t sel);
    int unsigned rate;
    case (sel)
      3'd0:    rate = 32'd300;
      3'd1:    rate = 32'd1_200;
      3'd2:    rate = 32'd4_800;
      3'd3:    rate = 32'd9_600;
      3'd4:    rate = 32'd19_200;
      3'd5:    rate = 32'd38_400;
      3'd6:    rate = 32'd57_600;
      default: rate = 32'd115_200;
    endcase
    return rate;
  endfunction

  // Accumulator increment: one sample tick per CLK_FREQ_HZ of accumulated phase.
  function automatic int unsigned baud_step(input baud_sel_t sel, input int unsigned oversample);
    return baud_rate(sel) * oversample;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Fractional phase accumulator producing the raw oversampling tick.
//   clk, reset   : clock, asynchronous active-low reset
//   enable       : advance the phase; low holds it
//   clear        : restart from phase zero (wins over enable)
//   step         : phase increment per clock
//   tick_c       : combinational, high when this edge crosses a modulus boundary
module baud_phase_acc #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned ACC_W       = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [ACC_W-1:0] step,
  output logic             tick_c
);

  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_FREQ_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;
  logic [ACC_W-1:0] acc_next_c;
  logic             wrap_c;

  // Add, compare against the modulus, subtract on wrap.
  always_comb begin
    acc_sum_c  = acc + step;
    wrap_c     = (acc_sum_c >= MODULUS);
    acc_next_c = acc_sum_c;
    if (wrap_c) begin
      acc_next_c = acc_sum_c - MODULUS;
    end
    tick_c = enable && !clear && wrap_c;
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_next_c;
    end
  end

endmodule

// File: rtl/baud_rate_generator.sv
// UART baud generator: oversampling, mid-bit and bit-rate strobes from a
// fractional phase accumulator, with rate-change and resync restart.
//   clk, reset    : clock, asynchronous active-low reset
//   enable        : run; low holds phase and suppresses strobes
//   resync        : restart bit timing from phase zero
//   baud_select   : rate code, registered internally
//   sample_ENABLE : one-cycle strobe at baud x OVERSAMPLE
//   mid_ENABLE    : strobe on sample tick OVERSAMPLE/2 of each bit
//   tx_ENABLE     : strobe on sample tick OVERSAMPLE of each bit
module baud_rate_generator
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       resync,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE,
  output logic       mid_ENABLE,
  output logic       tx_ENABLE
);

  localparam int unsigned ACC_W  = $clog2(CLK_FREQ_HZ + MAX_BAUD * OVERSAMPLE) + 1;
  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam logic [TCNT_W-1:0] MID_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] BIT_LAST = TCNT_W'(OVERSAMPLE - 1);

  // Parameter sanity: power-of-two oversample in range, at most one tick per clock.
  if ((OVERSAMPLE < MIN_OVERSAMPLE) || (OVERSAMPLE > MAX_OVERSAMPLE) ||
      ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
    $error("baud_rate_generator: OVERSAMPLE must be a power of two in 2..64");
  end
  if (CLK_FREQ_HZ <= MAX_BAUD * OVERSAMPLE) begin : g_bad_clk_freq
    $error("baud_rate_generator: CLK_FREQ_HZ must exceed 115200 x OVERSAMPLE");
  end

  baud_sel_t         bsel_q;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_next_c;
  logic [ACC_W-1:0]  step_c;
  logic              baud_change_c;
  logic              clear_c;
  logic              tick_c;
  logic              sample_next_c;
  logic              mid_next_c;
  logic              tx_next_c;

  // Restart conditions; STEP follows the registered code so a new rate starts
  // on the edge after the clear.
  always_comb begin
    baud_change_c = (baud_sel_t'(baud_select) != bsel_q);
    clear_c       = baud_change_c || resync;
    step_c        = ACC_W'(baud_step(bsel_q, OVERSAMPLE));
  end

  baud_phase_acc #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .ACC_W       (ACC_W)
  ) u_phase_acc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear_c),
    .step   (step_c),
    .tick_c (tick_c)
  );

  // Tick position within the bit and strobe decode; tick_c is already
  // suppressed on clear and when disabled.
  always_comb begin
    tcnt_next_c   = tcnt;
    sample_next_c = tick_c;
    mid_next_c    = tick_c && (tcnt == MID_LAST);
    tx_next_c     = tick_c && (tcnt == BIT_LAST);
    if (clear_c) begin
      tcnt_next_c = '0;
    end else if (tick_c) begin
      tcnt_next_c = tcnt + TCNT_W'(1);
    end
  end

  // Rate register, tick counter and output strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bsel_q        <= 3'b000;
      tcnt          <= '0;
      sample_ENABLE <= 1'b0;
      mid_ENABLE    <= 1'b0;
      tx_ENABLE     <= 1'b0;
    end else begin
      bsel_q        <= baud_sel_t'(baud_select);
      tcnt          <= tcnt_next_c;
      sample_ENABLE <= sample_next_c;
      mid_ENABLE    <= mid_next_c;
      tx_ENABLE     <= tx_next_c;
    end
  end

endmodule

// File: tb/tb_baud_rate_generator.sv
// Self-checking bench for baud_rate_generator: expected strobe edges are
// derived in closed form (tick i lands on edge clear + ceil(i*CLK/STEP)).
module tb_baud_rate_generator;

  localparam longint CLK_HZ = 50_000_000;
  localparam int     OS     = 16;
  localparam longint NO_GAP = 64'sd1 << 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       resync;
  logic [2:0] baud_select;
  logic       sample_ENABLE;
  logic       mid_ENABLE;
  logic       tx_ENABLE;

  baud_rate_generator #(
    .CLK_FREQ_HZ (50_000_000),
    .OVERSAMPLE  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .resync        (resync),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_ENABLE),
    .mid_ENABLE    (mid_ENABLE),
    .tx_ENABLE     (tx_ENABLE)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint edge_n;
    bit     mid;
    bit     tx;
  } ev_t;

  ev_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  int unsigned rate_tbl [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Free-run statistics window.
  bit     sb_on  = 1'b1;
  longint win_lo = 0;
  longint win_hi = -1;
  int     n_s = 0, n_m = 0, n_t = 0, bad_sp = 0, viol = 0;
  longint last_s = -1, min_sp = 1000000, max_sp = 0;
  logic   prev_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint step_of(input int sel);
    return longint'(rate_tbl[sel]) * OS;
  endfunction

  // Queue ticks 1..n after clear edge c; ticks whose nominal edge is past
  // gap_after are delayed by gap cycles (enable held low in between).
  task automatic push_events(input longint c, input longint step, input int n,
                             input longint gap_after, input longint gap);
    for (int i = 1; i <= n; i++) begin
      ev_t    e;
      longint b;
      b        = c + (longint'(i) * CLK_HZ + step - 1) / step;
      e.edge_n = (b > gap_after) ? b + gap : b;
      e.mid    = ((i % OS) == OS / 2);
      e.tx     = ((i % OS) == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic pulse_resync(output longint c);
    resync = 1'b1;
    @(posedge clk);
    #1;
    c      = cyc;
    resync = 1'b0;
  endtask

  // Output monitor: invariants, free-run statistics, scoreboard compare.
  always @(negedge clk) begin : monitor
    ev_t    e;
    longint sp;
    if ((mid_ENABLE || tx_ENABLE) && !sample_ENABLE) viol++;
    if (mid_ENABLE && tx_ENABLE) viol++;
    if (sample_ENABLE && prev_s) viol++;
    prev_s = sample_ENABLE;

    if (cyc >= win_lo && cyc <= win_hi) begin
      if (mid_ENABLE) n_m++;
      if (tx_ENABLE) n_t++;
      if (sample_ENABLE) begin
        n_s++;
        if (last_s >= 0) begin
          sp = cyc - last_s;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
          if (sp != 27 && sp != 28) bad_sp++;
        end
        last_s = cyc;
      end
    end

    if (sb_on) begin
      while (sb_q.size() != 0 && sb_q[0].edge_n < cyc) begin
        e = sb_q.pop_front();
        check("missed_strobe", cyc, e.edge_n);
      end
      if (sample_ENABLE || mid_ENABLE || tx_ENABLE) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", {sample_ENABLE, mid_ENABLE, tx_ENABLE}, 0);
        end else begin
          e = sb_q.pop_front();
          check("strobe_edge", cyc, e.edge_n);
          check("strobe_flags", {sample_ENABLE, mid_ENABLE, tx_ENABLE}, {1'b1, e.mid, e.tx});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint c, t, e_gap, t16;
    int     k;
    reset       = 1'b0;
    enable      = 1'b1;
    resync      = 1'b0;
    baud_select = 3'b011;
    repeat (3) @(negedge clk);
    check("rst_sample", sample_ENABLE, 0);
    check("rst_mid", mid_ENABLE, 0);
    check("rst_tx", tx_ENABLE, 0);

    // 9600 baud from reset release: the first edge sees 011 vs reset code 000
    // and clears; first tick 326 edges later, mid on tick 8, tx on tick 16.
    reset = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    push_events(c, step_of(3), 20, NO_GAP, 0);
    drain("t1_9600_first_bits", 7000);

    // Mid-bit switch to 115200: clear, then first tick 28 edges later.
    baud_select = 3'b111;
    @(posedge clk);
    #1;
    c = cyc;
    push_events(c, step_of(7), 16, NO_GAP, 0);
    drain("t2_rate_change", 600);

    // Resync landing exactly on the edge of the 17th tick.
    t = c + (17 * CLK_HZ + step_of(7) - 1) / step_of(7);
    k = 0;
    while (cyc != t - 1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    #1;
    pulse_resync(c);
    check("t3_resync_edge", c, t);
    push_events(c, step_of(7), 16, NO_GAP, 0);
    drain("t3_resync_on_tick", 600);

    // Enable low for 100 edges after tick 5: later ticks slip by exactly 100.
    pulse_resync(c);
    e_gap = c + (5 * CLK_HZ + step_of(7) - 1) / step_of(7) + 3;
    push_events(c, step_of(7), 12, e_gap, 100);
    k = 0;
    while (cyc != e_gap && k < 1000) begin
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    repeat (100) @(negedge clk);
    enable = 1'b1;
    drain("t4_enable_gap", 800);

    // Free run at 115200 over 31250 edges: exactly 1152 ticks, 72 bits.
    pulse_resync(c);
    sb_on  = 1'b0;
    n_s    = 0;
    n_m    = 0;
    n_t    = 0;
    bad_sp = 0;
    last_s = -1;
    min_sp = 1000000;
    max_sp = 0;
    win_lo = c + 1;
    win_hi = c + 31250;
    while (cyc < win_hi) @(negedge clk);
    #1;
    sb_on = 1'b1;
    check("free_samples", n_s, 1152);
    check("free_tx", n_t, 72);
    check("free_mid", n_m, 72);
    check("free_bad_spacing", bad_sp, 0);
    check("free_min_spacing", min_sp, 27);
    check("free_max_spacing", max_sp, 28);

    // Asynchronous reset while a tx strobe is high.
    pulse_resync(c);
    push_events(c, step_of(7), 16, NO_GAP, 0);
    t16 = c + (16 * CLK_HZ + step_of(7) - 1) / step_of(7);
    k = 0;
    while (cyc != t16 && k < 1000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("pre_rst_sample", sample_ENABLE, 1);
    check("pre_rst_tx", tx_ENABLE, 1);
    reset = 1'b0;
    #1;
    check("async_rst_outputs", {sample_ENABLE, mid_ENABLE, tx_ENABLE}, 0);
    sb_q.delete();
    baud_select = 3'b011;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    push_events(c, step_of(3), 1, NO_GAP, 0);
    drain("t6_first_after_reset", 400);

    check("strobe_invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
